tx_stream_fifo: RTL and testbench

APB-written transmit FIFO with a parametrised bit serializer, the next generation of the Zigbee TX path FIFO. Software pushes WIDTH-bit words over APB. The block buffers DEPTH words and shifts each word out one bit at a time, each bit lasting DIV system clocks, with a mid-bit strobe for the downstream modulator. Additions over the previous generation:
- selectable bit order;
- gap-free back-to-back words and whole-word completion when enable drops;
- sticky overflow and underflow flags, an almost-full flag, a readable status register and a flush command.

---
 rtl/tx_stream_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_tx_stream_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_fifo
// Purpose  : APB-written transmit FIFO feeding a bit serializer with
//            selectable bit order, mid-bit strobe and sticky status flags.
// Revision : 1.0 - initial release
// ============================================================================
module tx_stream_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int DIV      = 25,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        en,
  output logic        tx_data,
  output logic        tx_strobe,
  output logic        tx_busy,
  output logic        not_empty,
  output logic        almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_MID   = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [PW-1:0] AF_THR    = PW'(AF_LEVEL);
  localparam logic [3:0]    ADDR_DATA = 4'h0;
  localparam logic [3:0]    ADDR_CTRL = 4'h4;
  localparam logic [3:0]    ADDR_STAT = 4'h8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, level;
  logic             empty, full;
  logic             access, addr_ok, wr_data, wr_ctrl, wr_stat;
  logic             push, drop, flush;
  logic             msb_first, ovf, udf;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             msb_lat;
  logic [BW-1:0]    bit_cnt, bit_idx;
  logic [DW-1:0]    div_cnt;
  logic             bit_end, word_end, pop, udf_set;
  logic [31:0]      status_word;
  logic             unused_bits;

  // FIFO bookkeeping: the extra pointer bit separates full from empty
  assign level       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign not_empty   = !empty;
  assign almost_full = (level >= AF_THR);

  // APB decode; no wait states, errors only during the access phase
  assign access  = psel && penable;
  assign addr_ok = (paddr == ADDR_DATA) || (paddr == ADDR_CTRL) || (paddr == ADDR_STAT);
  assign wr_data = access && pwrite && (paddr == ADDR_DATA);
  assign wr_ctrl = access && pwrite && (paddr == ADDR_CTRL);
  assign wr_stat = access && pwrite && (paddr == ADDR_STAT);
  assign push    = wr_data && !full;
  assign drop    = wr_data && full;
  assign flush   = wr_ctrl && pwdata[1];
  assign pslverr = access && (!addr_ok || drop);
  assign pready  = 1'b1;

  // Upper data bits are ignored for DATA writes
  assign unused_bits = ^pwdata;

  // Assemble the status register image
  always_comb begin
    status_word         = '0;
    status_word[0]      = empty;
    status_word[1]      = full;
    status_word[2]      = almost_full;
    status_word[3]      = ovf;
    status_word[4]      = udf;
    status_word[5]      = tx_busy;
    status_word[8 +: PW] = level;
  end

  // Combinational read mux, zero unless a read is addressed
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_CTRL: prdata = {31'b0, msb_first};
        ADDR_STAT: prdata = status_word;
        default:   prdata = '0;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers guard them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pwdata[WIDTH-1:0];
  end

  // Pointer update; flush discards queued words but not the shifting one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Control bit and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msb_first <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (wr_ctrl) msb_first <= pwdata[0];
      if (drop)                      ovf <= 1'b1;
      else if (wr_stat && pwdata[3]) ovf <= 1'b0;
      if (udf_set)                   udf <= 1'b1;
      else if (wr_stat && pwdata[4]) udf <= 1'b0;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Serializer next state, pop request and serial outputs
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    udf_set   = 1'b0;
    tx_busy   = 1'b0;
    tx_strobe = 1'b0;
    tx_data   = 1'b0;
    bit_end   = (div_cnt == DIV_LAST);
    word_end  = bit_end && (bit_cnt == BIT_LAST);
    bit_idx   = msb_lat ? (BIT_LAST - bit_cnt) : bit_cnt;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        tx_busy   = 1'b1;
        tx_strobe = (div_cnt == DIV_MID);
        tx_data   = shreg[bit_idx];
        if (word_end) begin
          if (en && !empty) begin
            pop = 1'b1;
          end else begin
            state_nxt = IDLE;
            udf_set   = en;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit/divider counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      msb_lat <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr[AW-1:0]];
      msb_lat <= msb_first;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (bit_end) begin
        div_cnt <= '0;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_stream_fifo
// Purpose  : Directed, table-driven checks of the APB TX FIFO and serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_stream_fifo;

  localparam int DIV = 25;

  logic        clk, reset_n;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        en, tx_data, tx_strobe, tx_busy, not_empty, almost_full;

  int n_pass  = 0;
  int n_total = 0;
  int strobes = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  tx_stream_fifo #(.WIDTH(8), .DEPTH(64), .DIV(DIV), .AF_LEVEL(60)) dut (
    .clk(clk), .reset_n(reset_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .en(en), .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_busy(tx_busy),
    .not_empty(not_empty), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Called just after a rising edge; returns just after the access edge
  task automatic apb(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_chk(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, d, rd, err);
    chk({nm, " err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, a, 32'h0, rd, err);
    chk({nm, " rdata"}, rd, exp);
    chk({nm, " err"}, {31'b0, err}, 32'h0);
  endtask

  // One cycle of serial output; bits[k] is the k-th bit in time order
  task automatic chk_cycle(input int c, input logic [15:0] bits, input string nm);
    int k;
    k = c / DIV;
    chk($sformatf("%s data c%0d", nm, c), {31'b0, tx_data}, {31'b0, bits[k]});
    chk($sformatf("%s busy c%0d", nm, c), {31'b0, tx_busy}, 32'h1);
    chk($sformatf("%s strobe c%0d", nm, c), {31'b0, tx_strobe}, {31'b0, (c % DIV) == DIV / 2});
    if (tx_strobe) strobes++;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b0, 4'h8, 32'h0, 32'h1, 1'b0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 4'h4, 32'h1, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'h4, 32'h0, 32'h1, 1'b0};
    vecs[4]  = '{1'b1, 4'h4, 32'h3, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'h4, 32'h0, 32'h1, 1'b0};
    vecs[6]  = '{1'b1, 4'h4, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'hC, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b1, 4'h2, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 4'h1, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 4'h5, 32'h1, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 4'h4, 32'h0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 4'h8, 32'h18, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 4'h8, 32'h0, 32'h1, 1'b0};
    vecs[15] = '{1'b1, 4'hF, 32'hFF, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 4'h8, 32'h0, 32'h1, 1'b0};

    reset_n = 1'b0; en = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    chk("rst tx_data",     {31'b0, tx_data},     32'h0);
    chk("rst tx_strobe",   {31'b0, tx_strobe},   32'h0);
    chk("rst tx_busy",     {31'b0, tx_busy},     32'h0);
    chk("rst not_empty",   {31'b0, not_empty},   32'h0);
    chk("rst almost_full", {31'b0, almost_full}, 32'h0);
    chk("rst prdata",      prdata,               32'h0);
    chk("rst pslverr",     {31'b0, pslverr},     32'h0);
    chk("rst pready",      {31'b0, pready},      32'h1);

    // Register access table
    for (int i = 0; i < 17; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
    end
    chk("pslverr idle", {31'b0, pslverr}, 32'h0);

    // LSB-first 0xA5 with en held high, then underflow and its W1C
    en = 1'b1;
    wr_chk(4'h0, 32'hA5, 1'b0, "a5 push");
    chk("a5 not_empty", {31'b0, not_empty}, 32'h1);
    chk("a5 pre busy", {31'b0, tx_busy}, 32'h0);
    @(posedge clk); #1;
    strobes = 0;
    for (int c = 0; c < 8 * DIV; c++) begin
      chk_cycle(c, 16'h00A5, "a5");
      @(posedge clk); #1;
    end
    chk("a5 strobes", strobes, 8);
    chk("a5 end busy", {31'b0, tx_busy}, 32'h0);
    rd_chk(4'h8, 32'h11, "a5 status udf");
    wr_chk(4'h8, 32'h10, 1'b0, "udf w1c");
    rd_chk(4'h8, 32'h01, "udf cleared");

    // Fill to full with en low, then overflow
    en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      wr_chk(4'h0, i, 1'b0, $sformatf("fill%0d", i));
      chk($sformatf("fill%0d af", i), {31'b0, almost_full}, {31'b0, i >= 59});
    end
    rd_chk(4'h8, 32'h4006, "full status");
    wr_chk(4'h0, 32'h77, 1'b1, "ovf write");
    rd_chk(4'h8, 32'h400E, "ovf status");
    wr_chk(4'h4, 32'h2, 1'b0, "flush full");
    rd_chk(4'h8, 32'h0009, "flushed status");
    wr_chk(4'h8, 32'h08, 1'b0, "ovf w1c");
    rd_chk(4'h8, 32'h0001, "ovf cleared");

    // MSB-first back-to-back words with no gap
    wr_chk(4'h4, 32'h1, 1'b0, "msb set");
    wr_chk(4'h0, 32'h0F, 1'b0, "b2b push0");
    wr_chk(4'h0, 32'hF0, 1'b0, "b2b push1");
    en = 1'b1;
    @(posedge clk); #1;
    strobes = 0;
    for (int c = 0; c < 16 * DIV; c++) begin
      chk_cycle(c, 16'h0FF0, "b2b");
      @(posedge clk); #1;
    end
    chk("b2b strobes", strobes, 16);
    chk("b2b end busy", {31'b0, tx_busy}, 32'h0);
    en = 1'b0;
    wr_chk(4'h8, 32'h10, 1'b0, "b2b udf w1c");
    wr_chk(4'h4, 32'h0, 1'b0, "msb clear");
    rd_chk(4'h8, 32'h01, "b2b status");

    // en dropped mid-word: word completes, second word stays queued
    wr_chk(4'h0, 32'h3C, 1'b0, "drop push0");
    wr_chk(4'h0, 32'h81, 1'b0, "drop push1");
    en = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 8 * DIV; c++) begin
      if (c == 3 * DIV + 5) en = 1'b0;
      chk_cycle(c, 16'h003C, "drop");
      @(posedge clk); #1;
    end
    chk("drop end busy", {31'b0, tx_busy}, 32'h0);
    chk("drop not_empty", {31'b0, not_empty}, 32'h1);
    repeat (5) begin @(posedge clk); #1; end
    chk("drop stays idle", {31'b0, tx_busy}, 32'h0);
    rd_chk(4'h8, 32'h0100, "drop status");

    // Flush at bit 2 with five words queued
    wr_chk(4'h4, 32'h2, 1'b0, "pre flush");
    wr_chk(4'h0, 32'h81, 1'b0, "fl push0");
    wr_chk(4'h0, 32'h11, 1'b0, "fl push1");
    wr_chk(4'h0, 32'h22, 1'b0, "fl push2");
    wr_chk(4'h0, 32'h33, 1'b0, "fl push3");
    wr_chk(4'h0, 32'h44, 1'b0, "fl push4");
    rd_chk(4'h8, 32'h0500, "fl level5");
    en = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 8 * DIV; c++) begin
      if (c == 2 * DIV) begin
        chk("fl before not_empty", {31'b0, not_empty}, 32'h1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'h2;
      end else if (c == 2 * DIV + 1) begin
        penable = 1'b1;
      end else if (c == 2 * DIV + 2) begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("fl after not_empty", {31'b0, not_empty}, 32'h0);
      end
      chk_cycle(c, 16'h0081, "fl");
      @(posedge clk); #1;
    end
    chk("fl end busy", {31'b0, tx_busy}, 32'h0);
    rd_chk(4'h8, 32'h11, "fl status");
    en = 1'b0;
    wr_chk(4'h8, 32'h10, 1'b0, "fl udf w1c");

    // Asynchronous reset mid-word
    wr_chk(4'h0, 32'hFF, 1'b0, "rst push0");
    wr_chk(4'h0, 32'hFF, 1'b0, "rst push1");
    en = 1'b1;
    @(posedge clk); #1;
    repeat (30) begin @(posedge clk); #1; end
    chk("pre-rst tx_data", {31'b0, tx_data}, 32'h1);
    chk("pre-rst busy", {31'b0, tx_busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid-rst tx_data", {31'b0, tx_data}, 32'h0);
    chk("mid-rst busy", {31'b0, tx_busy}, 32'h0);
    chk("mid-rst not_empty", {31'b0, not_empty}, 32'h0);
    chk("mid-rst strobe", {31'b0, tx_strobe}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    en = 1'b0;
    rd_chk(4'h8, 32'h01, "post-rst status");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
